// File: rtl/axi_ni_request_scheduler.sv
// axi_ni_request_scheduler: round-robin AR/AW scheduler feeding the NI header and write-data path.
// Define AXI_NI_SCHED_WLAST_CHECK_EN to enable the sticky wlast/burst-length consistency flag.
`ifndef AXILENWD
`define AXILENWD 8
`endif

module axi_ni_request_scheduler #(
    parameter int LENWD = `AXILENWD
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             arvalid,
    input  logic [LENWD-1:0] arlen,
    output logic             arready,
    input  logic             awvalid,
    input  logic [LENWD-1:0] awlen,
    output logic             awready,
    input  logic             wvalid,
    input  logic             wlast,
    output logic             wready,
    output logic             write_select,
    output logic             hdr_valid,
    input  logic             hdr_ready,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             wlast_err
);
    localparam logic [1:0] IDLE = 2'd0, HDR = 2'd1, WDATA = 2'd2;

    logic [1:0]       state;
    logic             last_grant;
    logic [LENWD-1:0] len_q;
    logic [LENWD:0]   beat_cnt;
    logic             grant_w, beat, last_beat;

    // On a tie the channel opposite to the last served one wins
    assign grant_w    = awvalid & (~arvalid | ~last_grant);
    assign hdr_valid  = state == HDR;
    assign arready    = hdr_valid & hdr_ready & ~write_select;
    assign awready    = hdr_valid & hdr_ready & write_select;
    assign data_valid = (state == WDATA) & wvalid;
    assign wready     = (state == WDATA) & data_ready;
    assign beat       = data_valid & data_ready;
    assign last_beat  = beat_cnt == {1'b0, len_q};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            write_select <= 1'b0;
            len_q        <= '0;
            beat_cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (arvalid | awvalid) begin
                    write_select <= grant_w;
                    len_q        <= grant_w ? awlen : arlen;
                    beat_cnt     <= '0;
                    state        <= HDR;
                end
                HDR: if (hdr_ready) begin
                    last_grant <= write_select;
                    state      <= write_select ? WDATA : IDLE;
                end
                WDATA: if (beat) begin
                    beat_cnt <= beat_cnt + 1'b1;
                    if (last_beat) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_NI_SCHED_WLAST_CHECK_EN
    always_ff @(posedge clock) begin
        if (!reset_n) wlast_err <= 1'b0;
        else if (beat && (wlast != last_beat)) wlast_err <= 1'b1;
    end
`else
    // wlast is only observed by the optional checker
    assign wlast_err = 1'b0 & wlast;
`endif
endmodule

// File: tb/tb_axi_ni_request_scheduler.sv
// tb_axi_ni_request_scheduler: vector table, corner sequences and random run against a transaction-level model.
module tb_axi_ni_request_scheduler;
    logic       clock = 1'b0, reset_n = 1'b0;
    logic       arvalid = 1'b0, awvalid = 1'b0, hdr_ready = 1'b0, wvalid = 1'b0, wlast = 1'b0, data_ready = 1'b0;
    logic [3:0] arlen = '0, awlen = '0;
    logic       arready, awready, wready, write_select, hdr_valid, data_valid, wlast_err;
    int         n_chk = 0, n_fail = 0;

    typedef struct packed {
        logic       arv;
        logic [3:0] arl;
        logic       awv;
        logic [3:0] awl;
        logic       hr, wv, wl, dr;
    } in_t;
    typedef struct packed {
        in_t        i;
        logic [6:0] e;
    } vec_t;

    axi_ni_request_scheduler #(.LENWD(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .arvalid(arvalid), .arlen(arlen), .arready(arready),
        .awvalid(awvalid), .awlen(awlen), .awready(awready),
        .wvalid(wvalid), .wlast(wlast), .wready(wready),
        .write_select(write_select), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .data_valid(data_valid), .data_ready(data_ready), .wlast_err(wlast_err)
    );

    always #5 clock = ~clock;

    function automatic logic [6:0] outs();
        return {hdr_valid, arready, awready, write_select, wready, data_valid, wlast_err};
    endfunction

    function automatic in_t mk(int a, int al, int w, int wl_, int h, int v, int l, int d);
        return '{a[0], al[3:0], w[0], wl_[3:0], h[0], v[0], l[0], d[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input in_t v);
        @(negedge clock);
        {arvalid, arlen, awvalid, awlen, hdr_ready, wvalid, wlast, data_ready} = v;
        #2;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        {arvalid, arlen, awvalid, awlen, hdr_ready, wvalid, wlast, data_ready} = '0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Reference: one outstanding transaction with a remaining-beat countdown
    logic m_act, m_hd, m_kind, m_ws, m_last, m_err;
    int   m_left;
    initial begin
        logic [6:0] e;
        @(posedge clock);
        forever begin
            if (!reset_n) begin
                m_act = 0; m_hd = 0; m_kind = 0; m_ws = 0; m_last = 1; m_err = 0; m_left = 0;
            end else if (!m_act) begin
                if (arvalid || awvalid) begin
                    m_kind = (arvalid && awvalid) ? !m_last : awvalid;
                    m_ws   = m_kind;
                    m_left = (m_kind ? int'(awlen) : int'(arlen)) + 1;
                    m_act  = 1; m_hd = 0;
                end
            end else if (!m_hd) begin
                if (hdr_ready) begin
                    m_last = m_kind;
                    if (m_kind) m_hd = 1; else m_act = 0;
                end
            end else if (wvalid && data_ready) begin
`ifdef AXI_NI_SCHED_WLAST_CHECK_EN
                if (wlast != (m_left == 1)) m_err = 1;
`endif
                m_left--;
                if (m_left == 0) m_act = 0;
            end
            @(negedge clock); #1;
            e = {m_act && !m_hd, m_act && !m_hd && hdr_ready && !m_kind, m_act && !m_hd && hdr_ready && m_kind,
                 m_ws, m_act && m_hd && data_ready, m_act && m_hd && wvalid, m_err};
            chk("model_cycle", outs(), e);
            @(posedge clock);
        end
    end

    vec_t tbl[12];
    logic exp_err;

    initial begin
        int nh, nr, nb, lastk;
`ifdef AXI_NI_SCHED_WLAST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        // outputs: {hdr_valid, arready, awready, write_select, wready, data_valid, wlast_err}
        tbl[0]  = '{mk(1,3,0,0,1,0,0,0), 7'b0000000};
        tbl[1]  = '{mk(1,3,0,0,1,0,0,0), 7'b1100000};
        tbl[2]  = '{mk(0,0,1,1,0,0,0,0), 7'b0000000};
        tbl[3]  = '{mk(0,0,1,1,0,0,0,0), 7'b1001000};
        tbl[4]  = '{mk(0,0,1,1,1,0,0,0), 7'b1011000};
        tbl[5]  = '{mk(0,0,0,0,0,1,0,0), 7'b0001010};
        tbl[6]  = '{mk(0,0,0,0,0,1,0,1), 7'b0001110};
        tbl[7]  = '{mk(0,0,0,0,0,0,0,1), 7'b0001100};
        tbl[8]  = '{mk(1,0,0,0,0,1,1,1), 7'b0001110};
        tbl[9]  = '{mk(1,0,0,0,0,1,0,1), 7'b0001000};
        tbl[10] = '{mk(1,0,0,0,1,0,0,0), 7'b1100000};
        tbl[11] = '{mk(0,0,0,0,0,0,0,0), 7'b0000000};

        do_reset();
        #1 chk("reset_outs", outs(), 0);
        for (int k = 0; k < 12; k++) begin
            cyc(tbl[k].i);
            chk($sformatf("vec%0d", k), outs(), tbl[k].e);
        end

        // Tie after reset: read first, then alternate
        do_reset();
        begin
            logic q[$];
            for (int c = 0; c < 40 && q.size() < 4; c++) begin
                cyc(mk(1,0,1,0,1,1,1,1));
                if (hdr_valid) q.push_back(write_select);
            end
            chk("tie_count", q.size(), 4);
            for (int k = 0; k < q.size(); k++) chk($sformatf("tie_grant%0d", k), q[k], k % 2);
        end

        // Header back-pressure then half-rate data
        do_reset();
        nh = 0; nr = 0; nb = 0; lastk = -1;
        cyc(mk(0,0,1,3,0,0,0,0));
        for (int c = 1; c <= 6; c++) begin
            cyc(mk(0,0,1,3,(c == 6),0,0,0));
            nh += hdr_valid; nr += awready;
        end
        chk("bp_hdr_cycles", nh, 6);
        chk("bp_awready_pulses", nr, 1);
        for (int k = 0; k < 20; k++) begin
            cyc(mk(0,0,0,0,0,1,(nb == 3),k % 2));
            if (wready && data_valid) begin nb++; lastk = k; end
        end
        chk("bp_beats", nb, 4);
        chk("bp_last_beat_cycle", lastk, 7);

        // Maximum burst length
        do_reset();
        nb = 0;
        cyc(mk(0,0,1,15,1,0,0,0));
        cyc(mk(0,0,1,15,1,0,0,0));
        for (int k = 0; k < 22; k++) begin
            cyc(mk(0,0,0,0,0,1,(nb == 15),1));
            if (wready && data_valid) nb++;
        end
        chk("max_beats", nb, 16);

        // Early wlast still runs the counted burst
        do_reset();
        nb = 0;
        cyc(mk(0,0,1,1,1,0,0,0));
        cyc(mk(0,0,1,1,1,0,0,0));
        for (int k = 0; k < 6; k++) begin
            cyc(mk(0,0,0,0,0,1,1,1));
            if (wready && data_valid) nb++;
        end
        chk("wlast_beats", nb, 2);
        chk("wlast_err_set", wlast_err, exp_err);
        repeat (3) cyc(mk(0,0,0,0,0,0,0,0));
        chk("wlast_err_sticky", wlast_err, exp_err);

        // Reset in the middle of a burst
        do_reset();
        cyc(mk(0,0,1,7,1,0,0,0));
        cyc(mk(0,0,1,7,1,0,0,0));
        cyc(mk(0,0,0,0,0,1,1,1));
        cyc(mk(0,0,0,0,0,1,1,1));
        chk("mid_burst_active", wready, 1);
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock); #1;
        chk("mid_reset_outs", outs(), 0);
        @(negedge clock);
        reset_n = 1'b1;
        cyc(mk(0,0,0,0,0,1,0,1));
        chk("post_reset_idle", outs(), 0);

        for (int c = 0; c < 3000; c++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            cyc(mk($urandom_range(0,2) == 0, $urandom_range(0,15), $urandom_range(0,2) == 0, $urandom_range(0,3),
                   $urandom_range(0,1), $urandom_range(0,3) != 0, $urandom_range(0,1), $urandom_range(0,3) != 0));
        end

        @(negedge clock); #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_ni_request_scheduler.md
# axi_ni_request_scheduler

Sequences the AXI slave-side address and write-data channels into the NI packetizer. Arbitrates AR against AW round-robin, holds `write_select` stable toward `axi_ni_request_encoder` while a request header is emitted, then forwards exactly `alen+1` write beats before accepting the next request. Sits between the AXI slave port and the request encoder/packetizer inside the initiator NI.

## Interface

Parameters:
- `LENWD`, default `` `AXILENWD ``: width of `arlen`/`awlen`.

Ports:
- `clock`  in  1  sole clock; all logic is rising-edge.
- `reset_n`  in  1  reset; synchronous, active-low.
- `arvalid`  in  1  AXI read-address valid.
- `arlen`  in  LENWD  AXI read burst length minus 1.
- `arready`  out  1  AXI read-address ready.
- `awvalid`  in  1  AXI write-address valid.
- `awlen`  in  LENWD  AXI write burst length minus 1.
- `awready`  out  1  AXI write-address ready.
- `wvalid`  in  1  AXI write-data valid.
- `wlast`  in  1  AXI write-data last.
- `wready`  out  1  AXI write-data ready.
- `write_select`  out  1  encoder mux select: 1 = AW/W, 0 = AR.
- `hdr_valid`  out  1  request header valid toward the packetizer.
- `hdr_ready`  in  1  packetizer accepts header.
- `data_valid`  out  1  write payload beat valid toward the packetizer.
- `data_ready`  in  1  packetizer accepts payload beat.
- `wlast_err`  out  1  sticky protocol error flag (see Configuration).

## Operation

- FSM states: IDLE, HDR, WDATA.
- IDLE:
  - No valid request: stay in IDLE.
  - Only one of `arvalid`/`awvalid` set: grant it.
  - Both set: grant the channel opposite to `last_grant`.
  - On a grant: register `write_select`, latch the granted `alen` into `len_q`, clear `beat_cnt`, go to HDR.
- HDR:
  - `hdr_valid`=1.
  - When `hdr_ready`=1: pulse `arready` (read) or `awready` (write) combinationally that cycle. This is `hdr_valid & hdr_ready & ±write_select`.
  - Update `last_grant` to the served channel.
  - Next state is WDATA for a write, IDLE for a read.
  - The AXI address stays stable through the encoder until the handshake, because the ready is issued only on header acceptance.
- WDATA:
  - `data_valid` = `wvalid`; `wready` = `data_ready`.
  - A beat transfers when `wvalid & data_ready`; `beat_cnt` increments.
  - On the beat where `beat_cnt == len_q`, go to IDLE.
  - `beat_cnt` is LENWD+1 bits, so `alen` all-ones (maximum burst) counts without wrap.
- `write_select` changes only on the IDLE to HDR transition. It is held through HDR and WDATA.
- `wready`/`data_valid` are 0 outside WDATA; W beats arriving early are back-pressured.
- Reset values:
  - state IDLE
  - `last_grant`=1 (write), so a read wins the first tie
  - `write_select`=0, `len_q`=0, `beat_cnt`=0
  - all ready/valid outputs 0
  - `wlast_err`=0
- Reset asserted mid-burst aborts to IDLE on the next edge. Partial beats are not replayed.

## Timing

- Request-to-header latency: `hdr_valid` rises 1 cycle after a valid request is seen in IDLE.
- Header handshake: `arready`/`awready` are asserted in the same cycle as `hdr_valid & hdr_ready`.
- `hdr_valid` is held while `hdr_ready`=0 and never drops before acceptance.
- W path is combinational pass-through: `wready` = `data_ready` in WDATA, zero added latency per beat.
- After the final W beat (or a read header), IDLE arbitrates on the next cycle. Minimum gap between two headers is 1 idle cycle.
- Simultaneous new `arvalid` during WDATA is ignored until IDLE. The read is never granted mid-burst.

## Configuration

- `AXI_NI_SCHED_WLAST_CHECK_EN` defined:
  - On every transferred beat, compare `wlast` with (`beat_cnt == len_q`).
  - On mismatch, set `wlast_err`. It is sticky until reset.
  - The FSM still terminates on the count, not on `wlast`.
- Undefined: no checker logic; `wlast_err` is tied to 0.

## Test plan

- Read only: `arvalid`=1, `arlen`=3, `hdr_ready`=1 -> `hdr_valid` at cycle 1, `arready` pulse at cycle 1, `write_select`=0, back to IDLE at cycle 2.
- Write burst: `awlen`=3, `hdr_ready`=1, `wvalid`=`data_ready`=1 -> `awready` once, exactly 4 `wready` beats, `write_select`=1 throughout, IDLE afterward.
- Tie after reset: `arvalid`=`awvalid`=1 continuously with `awlen`=0 -> grant order R, W, R, W.
- Back-pressure: `hdr_ready`=0 for 5 cycles, then 1 -> `hdr_valid` held 6 cycles, single ready pulse on the 6th; `data_ready` toggling halves the beat rate with the count still exact.
- Maximum length: `awlen`=all-ones -> 2^LENWD beats forwarded, no early exit.
- With the macro defined: `awlen`=1, `wlast`=1 on beat 0 -> `wlast_err`=1 and remains 1; FSM still takes 2 beats. Without the macro: `wlast_err` stays 0. Reset mid-burst -> IDLE next edge, all outputs at reset values.
